optical_receiver: RTL and testbench

Receive end of the fpga1 optical link. Recovers 28-bit words from the single-bit optical comparator input by start-bit detection and mid-bit sampling. Checks the even-parity bit produced by the transmitter and flags stop-bit errors. Presents each word to downstream logic as a one-cycle valid pulse.

---
 rtl/optical_pkg.sv | 9 +
 rtl/bit_synchronizer.sv | 12 +
 rtl/optical_receiver.sv | 81 ++++++++
 tb/tb_optical_receiver.sv | 125 ++++++++++++
 4 files changed

// File: rtl/optical_pkg.sv
// optical_pkg: shared link constants, rx state encoding and the even-parity convention
package optical_pkg;
  localparam int DATA_WIDTH = 28;
  localparam int FRAME_BITS = 31;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_e;
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: 2-flop synchronizer resetting to 1 (clk, rst, async d -> q)
module bit_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/optical_receiver.sv
// optical_receiver: recovers parity/stop-checked 28-bit words from rx_in (clk, rst, rx_in -> data_out, data_valid, parity_error, frame_error, busy)
module optical_receiver
  import optical_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  rx_state_e             state;
  logic                  rx_s;
  logic [CW-1:0]         cnt;
  logic [4:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] word;
  logic                  par;
  logic                  tick;
  bit_synchronizer u_sync (.clk(clk), .rst(rst), .d(rx_in), .q(rx_s));
  assign tick = cnt == LAST;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      word         <= '0;
      par          <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state   <= START;
          cnt     <= '0;
          bit_cnt <= '0;
          par     <= 1'b0;
        end
        START: if (cnt == HALF_M1) begin
          cnt   <= '0;
          state <= rx_s ? IDLE : DATA;
        end
        DATA: if (tick) begin
          cnt           <= '0;
          word[bit_cnt] <= rx_s;
          par           <= par ^ rx_s;
          bit_cnt       <= bit_cnt == 5'd27 ? 5'd0 : bit_cnt + 5'd1;
          state         <= bit_cnt == 5'd27 ? PARITY : DATA;
        end
        // folding the parity bit into the running XOR leaves par = 1 exactly on a parity error
        PARITY: if (tick) begin
          cnt   <= '0;
          par   <= par ^ rx_s;
          state <= STOP;
        end
        // leaving at mid-stop lets a back-to-back start edge be caught in IDLE
        STOP: if (tick) begin
          cnt          <= '0;
          data_out     <= word;
          data_valid   <= 1'b1;
          parity_error <= par;
          frame_error  <= !rx_s;
          state        <= rx_s ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_optical_receiver.sv
// tb_optical_receiver: scoreboard bench driving serialized frames into optical_receiver
module tb_optical_receiver;
  localparam int CPB = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT = 2 + HALF + 30 * CPB + 1;
  typedef struct {
    logic [27:0] d;
    logic        pe;
    logic        fe;
    int          t;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_in = 1'b1;
  logic [27:0] data_out;
  logic        data_valid, parity_error, frame_error, busy;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          prev_v = 0;
  int          last_v = 0;
  logic        prev_valid = 1'b0;
  exp_t        sb[$];

  optical_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(data_out), .data_valid(data_valid),
    .parity_error(parity_error), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // frame bits LSB first: start, d[0..27], parity, stop (stop held stop_len bit times)
  task automatic send(input logic [27:0] d, input logic p, input logic s, input int stop_len,
                      input int nbits, input bit push, input logic pe, input logic fe);
    logic [30:0] f;
    f = {s, p, d, 1'b0};
    if (push) sb.push_back('{d, pe, fe, cyc + LAT});
    for (int i = 0; i < nbits; i++) begin
      rx_in = f[i];
      repeat (i == 30 ? CPB * stop_len : CPB) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        check("valid_not_consecutive", {31'b0, prev_valid}, 32'd0);
        prev_v = last_v;
        last_v = cyc;
        if (sb.size() == 0) begin
          check("unexpected_valid_data", {4'b0, data_out}, 32'hFFFFFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data_out", {4'b0, data_out}, {4'b0, e.d});
          check("parity_error", {31'b0, parity_error}, {31'b0, e.pe});
          check("frame_error", {31'b0, frame_error}, {31'b0, e.fe});
          check("valid_cycle", cyc, e.t);
        end
      end
      prev_valid = data_valid;
    end else prev_valid = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data_out", {4'b0, data_out}, 32'd0);
    check("rst_data_valid", {31'b0, data_valid}, 32'd0);
    check("rst_parity_error", {31'b0, parity_error}, 32'd0);
    check("rst_frame_error", {31'b0, frame_error}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(28'h0000001, 1'b1, 1'b1, 1, 31, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    send(28'hFFFFFFE, 1'b0, 1'b1, 1, 31, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    send(28'b1001_0100_1011_1010_1000_1111_1000, 1'b0, 1'b0, 3, 31, 1'b1, 1'b0, 1'b1);
    check("busy_during_break", {31'b0, busy}, 32'd1);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_after_break", {31'b0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_in_glitch", {31'b0, busy}, 32'd1);
    repeat (HALF + 3) @(negedge clk);
    check("busy_after_glitch", {31'b0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    send(28'h0000001, 1'b1, 1'b1, 1, 31, 1'b1, 1'b0, 1'b0);
    send(28'hFFFFFFE, 1'b1, 1'b1, 1, 31, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("b2b_spacing", last_v - prev_v, 32'd248);
    send(28'h0000000, 1'b0, 1'b1, 1, 11, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("busy_after_abort", {31'b0, busy}, 32'd0);
    check("data_out_after_abort", {4'b0, data_out}, 32'd0);
    repeat (10) @(negedge clk);
    send(28'h5A5A5A5, 1'b0, 1'b1, 1, 31, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
